mod_select_seq: RTL and testbench
=================================

// Module: mod_select_seq
// PURPOSE
// - Sequential, parametrised mod-compare-select datapath unit.
// - Per transaction: g = A mod C, compare g with Zero, then Z = (g == Zero) ? A-1 : C+1.
// - Mod is iterative (1 quotient bit/cycle), not a combinational divider, so wide DATAWIDTH meets timing.
// - Valid/ready handshakes on input and output let it chain with other datapath units.
// PARAMETERS
// - DATAWIDTH  64  operand/result width in bits; legal range >= 2.
// - CNTW       $clog2(DATAWIDTH+1)  iteration counter width; derived, do not override.
// PORTS
// - Clk       in   1          rising-edge clock; the only clock.
// - Rst       in   1          asynchronous, active-low reset; Rst=0 clears all state immediately.
// - InValid   in   1          A/C/Zero valid this cycle.
// - InReady   out  1          unit can accept an operand set.
// - A         in   DATAWIDTH  dividend, unsigned.
// - C         in   DATAWIDTH  divisor, unsigned.
// - Zero      in   DATAWIDTH  compare operand for the remainder.
// - OutValid  out  1          Z/Rem/Eq/DivZero valid.
// - OutReady  in   1          consumer accepts the result.
// - Z         out  DATAWIDTH  selected result.
// - Rem       out  DATAWIDTH  g = A mod C.
// - Eq        out  1          g == Zero.
// - Gt, Lt    out  1          g > Zero, g < Zero (unsigned).
// - DivZero   out  1          C was 0 for this transaction.
// BEHAVIOUR
// - Reset values: InReady=1, OutValid=0, Z=Rem=0, Eq=Gt=Lt=DivZero=0, state=IDLE, counter=0.
// - Input accept: on InValid & InReady, capture A, C and Zero into internal registers.
// - Captured operands are held stable internally; inputs may change after acceptance.
// - IDLE: InReady=1.
//   - Accept with C!=0: go to CALC.
//   - Accept with C==0: go to CMP with g:=A and DivZero:=1 (A mod 0 is defined as A).
// - CALC: InReady=0. Restoring remainder runs for exactly DATAWIDTH cycles, MSB first.
//   - Each cycle: r = {r[W-2:0], a_msb}; if r >= C then r = r - C.
//   - The compare uses a W+1-bit internal width so there is no overflow when C > 2^(W-1).
// - CMP: one cycle. Register g, Eq, Gt and Lt.
//   - Z = Eq ? A-1 : C+1, modulo 2^DATAWIDTH.
//   - A=0 gives all-ones; C=all-ones gives 0.
//   - Go to DONE.
// - DONE: OutValid=1 and all outputs held stable until OutValid & OutReady.
//   - On that handshake: OutValid=0 next cycle, return to IDLE with InReady=1.
// - Latency from accept to OutValid: DATAWIDTH+2 cycles if C!=0; 2 cycles if C==0.
// - No overlap: one transaction in flight. InReady is low in CALC, CMP and DONE.
// - OutReady high before OutValid has no effect. A new accept is possible the cycle after the output handshake.
// - Rst asserted mid-CALC/DONE: the in-flight result is discarded and all outputs return to reset values.
// - Eq, Gt and Lt are mutually exclusive; exactly one is 1 whenever OutValid=1.
// STRUCTURE
// - Shared package: state encoding constants (IDLE, CALC, CMP, DONE); CNTW derivation function.
// - Sub-module mod_seq_core: iterative restoring remainder.
//   - Ports: Clk, Rst, Start, Dividend, Divisor, Busy, Done, Remainder.
//   - The top FSM sequences it and owns the compare, inc/dec and select.
// - Top level: FSM, operand registers, output registers.
// TESTING
// - W=64, A=10, C=5, Zero=0 -> Rem=0, Eq=1, Z=9, DivZero=0, OutValid exactly 66 cycles after accept.
// - A=10, C=3, Zero=0 -> Rem=1, Gt=1, Eq=0, Z=4.
// - A=0, C=7, Zero=0 -> Rem=0, Eq=1, Z=64'hFFFF_FFFF_FFFF_FFFF (dec wrap).
// - A=1, C=64'hFFFF_FFFF_FFFF_FFFF, Zero=0 -> Rem=1, Z=0 (inc wrap).
// - A=C=64'h8000_0000_0000_0001 -> Rem=0 (exercises the wide internal compare).
// - A=10, C=0, Zero=10 -> DivZero=1, Rem=10, Eq=1, Z=9, latency 2.
// - OutReady held 0 for 20 cycles in DONE -> outputs stable, InReady=0, InValid pulses ignored.
//   - Then OutReady=1 -> handshake, InReady=1 next cycle.
// - Rst=0 pulsed at cycle 30 of CALC -> all outputs immediately reset.
//   - After release, a new A=12, C=4 transaction completes correctly with Z=11.

Source files
------------

// File: rtl/mod_select_seq_pkg.sv
// Shared types and helpers for the mod-compare-select unit.
// Holds the FSM state encoding and the counter width derivation.
package mod_select_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } stateT;

   function automatic int cntWidth(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mod_select_seq_core.sv
// Iterative restoring remainder, one dividend bit per cycle, MSB first.
// Done is high during the final iteration cycle.
module mod_seq_core
   import mod_select_seq_pkg::*;
#(
   parameter int W    = 64,
   parameter int CNTW = cntWidth(W)
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [W-1:0] Dividend,
   input  logic [W-1:0] Divisor,
   output logic         Busy,
   output logic         Done,
   output logic [W-1:0] Remainder
);

   localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

   logic [W-1:0]    shiftReg;
   logic [W-1:0]    divReg;
   logic [CNTW-1:0] cnt;
   logic [W:0]      trial;
   logic [W-1:0]    diff;
   logic            fits;

   // Trial value keeps the carried-out bit so large divisors compare correctly
   always_comb begin
      trial = {Remainder, shiftReg[W-1]};
      diff  = trial[W-1:0] - divReg;
      fits  = trial >= {1'b0, divReg};
   end

   assign Done = Busy && (cnt == LAST);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         shiftReg  <= '0;
         divReg    <= '0;
         Remainder <= '0;
         cnt       <= '0;
         Busy      <= 1'b0;
      end else if (Start) begin
         shiftReg  <= Dividend;
         divReg    <= Divisor;
         Remainder <= '0;
         cnt       <= '0;
         Busy      <= 1'b1;
      end else if (Busy) begin
         Remainder <= fits ? diff : trial[W-1:0];
         shiftReg  <= {shiftReg[W-2:0], 1'b0};
         cnt       <= Done ? '0 : cnt + CNTW'(1);
         if (Done) Busy <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_select_seq.sv
// Sequential mod-compare-select: g = A mod C, Z = (g == Zero) ? A-1 : C+1.
// One transaction in flight, valid/ready on both sides.
module mod_select_seq
   import mod_select_seq_pkg::*;
#(
   parameter int DATAWIDTH = 64,
   parameter int CNTW      = cntWidth(DATAWIDTH)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 InValid,
   output logic                 InReady,
   input  logic [DATAWIDTH-1:0] A,
   input  logic [DATAWIDTH-1:0] C,
   input  logic [DATAWIDTH-1:0] Zero,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [DATAWIDTH-1:0] Z,
   output logic [DATAWIDTH-1:0] Rem,
   output logic                 Eq,
   output logic                 Gt,
   output logic                 Lt,
   output logic                 DivZero
);

   localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

   stateT state, nextState;

   logic [DATAWIDTH-1:0] aReg, cReg, zeroReg;
   logic [DATAWIDTH-1:0] coreRem, gVal;
   logic                 divZeroReg;
   logic                 accept, cIsZero, coreStart;
   logic                 coreBusy, coreDone;

   assign InReady   = (state == IDLE);
   assign OutValid  = (state == DONE);
   assign accept    = InValid && InReady;
   assign cIsZero   = (C == '0);
   assign coreStart = accept && !cIsZero && !coreBusy;
   assign gVal      = divZeroReg ? aReg : coreRem;

   mod_seq_core #(
      .W    (DATAWIDTH),
      .CNTW (CNTW)
   ) core (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (coreStart),
      .Dividend  (A),
      .Divisor   (C),
      .Busy      (coreBusy),
      .Done      (coreDone),
      .Remainder (coreRem)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (accept) nextState = cIsZero ? CMP : CALC;
         CALC: if (coreDone) nextState = CMP;
         CMP:  nextState = DONE;
         DONE: if (OutReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         aReg       <= '0;
         cReg       <= '0;
         zeroReg    <= '0;
         divZeroReg <= 1'b0;
      end else if (accept) begin
         aReg       <= A;
         cReg       <= C;
         zeroReg    <= Zero;
         divZeroReg <= cIsZero;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Z       <= '0;
         Rem     <= '0;
         Eq      <= 1'b0;
         Gt      <= 1'b0;
         Lt      <= 1'b0;
         DivZero <= 1'b0;
      end else if (state == CMP) begin
         Rem     <= gVal;
         Eq      <= gVal == zeroReg;
         Gt      <= gVal > zeroReg;
         Lt      <= gVal < zeroReg;
         DivZero <= divZeroReg;
         Z       <= (gVal == zeroReg) ? aReg - ONE : cReg + ONE;
      end
   end

endmodule

// File: tb/tb_mod_select_seq.sv
// Directed bench for mod_select_seq with a reference-model scoreboard.
// Latency counts rising edges from the accept edge, inclusive.
module tb_mod_select_seq;

   typedef struct {
      logic [63:0] z;
      logic [63:0] rem;
      logic        eq;
      logic        gt;
      logic        lt;
      logic        dz;
      int          lat;
   } expT;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [63:0] A = '0;
   logic [63:0] C = '0;
   logic [63:0] Zero = '0;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic [63:0] Z, Rem;
   logic        Eq, Gt, Lt, DivZero;

   int   errors = 0;
   int   checks = 0;
   expT  sb[$];

   mod_select_seq #(.DATAWIDTH(64)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .InValid  (InValid),
      .InReady  (InReady),
      .A        (A),
      .C        (C),
      .Zero     (Zero),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Z        (Z),
      .Rem      (Rem),
      .Eq       (Eq),
      .Gt       (Gt),
      .Lt       (Lt),
      .DivZero  (DivZero)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic expT model(input logic [63:0] a, c, zr);
      expT e;
      e.rem = (c == 64'd0) ? a : a % c;
      e.eq  = e.rem == zr;
      e.gt  = e.rem > zr;
      e.lt  = e.rem < zr;
      e.z   = e.eq ? a - 64'd1 : c + 64'd1;
      e.dz  = c == 64'd0;
      e.lat = (c == 64'd0) ? 2 : 66;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] a, c, zr);
      sb.push_back(model(a, c, zr));
      A = a;
      C = c;
      Zero = zr;
      InValid = 1'b1;
      chk("inReadyBeforeAccept", 64'(InReady), 64'd1);
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      A = ~a;
      C = ~c;
      Zero = ~zr;
   endtask

   task automatic recv(input int hold);
      expT e;
      int  lat;
      lat = 1;
      while (!OutValid && lat < 200) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      chk("outValidSeen", 64'(OutValid), 64'd1);
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboardEmpty observed=0 expected=1 entry");
      end else begin
         e = sb.pop_front();
         chk("latency", 64'(lat), 64'(e.lat));
         chk("Z", Z, e.z);
         chk("Rem", Rem, e.rem);
         chk("flags", {60'd0, Eq, Gt, Lt, DivZero},
             {60'd0, e.eq, e.gt, e.lt, e.dz});
         chk("oneHotFlags", 64'(Eq + Gt + Lt), 64'd1);
         for (int i = 0; i < hold; i++) begin
            InValid = 1'b1;
            A = 64'($urandom);
            C = 64'd3;
            @(posedge Clk);
            #1;
            chk("holdOutValid", 64'(OutValid), 64'd1);
            chk("holdInReady", 64'(InReady), 64'd0);
            chk("holdZ", Z, e.z);
            chk("holdRem", Rem, e.rem);
         end
         InValid = 1'b0;
      end
      OutReady = 1'b1;
      @(posedge Clk);
      #1;
      OutReady = 1'b0;
      chk("postHsOutValid", 64'(OutValid), 64'd0);
      chk("postHsInReady", 64'(InReady), 64'd1);
   endtask

   initial begin
      #2;
      chk("rstInReady", 64'(InReady), 64'd1);
      chk("rstOutValid", 64'(OutValid), 64'd0);
      chk("rstZRem", Z | Rem, 64'd0);
      chk("rstFlags", {60'd0, Eq, Gt, Lt, DivZero}, 64'd0);
      #10;
      Rst = 1'b1;
      @(posedge Clk);
      #1;

      OutReady = 1'b1;
      send(64'd10, 64'd5, 64'd0);
      OutReady = 1'b0;
      recv(0);
      chk("firstZ", Z, 64'd9);

      send(64'd10, 64'd3, 64'd0);
      recv(0);
      send(64'd0, 64'd7, 64'd0);
      recv(0);
      chk("decWrap", Z, 64'hFFFF_FFFF_FFFF_FFFF);
      send(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      recv(0);
      chk("incWrap", Z, 64'd0);
      send(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'd0);
      recv(0);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd5);
      recv(0);
      send(64'd100, 64'd7, 64'd9);
      recv(0);
      send(64'd10, 64'd0, 64'd10);
      recv(0);
      chk("divZeroRem", Rem, 64'd10);

      send({32'($urandom), 32'($urandom)}, 64'($urandom_range(1, 1000)),
           64'd2);
      recv(20);
      repeat (3) begin
         @(posedge Clk);
         #1;
         chk("noGhostTxn", 64'(OutValid), 64'd0);
      end

      send(64'd100, 64'd7, 64'd0);
      repeat (29) @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("midRstOutValid", 64'(OutValid), 64'd0);
      chk("midRstInReady", 64'(InReady), 64'd1);
      chk("midRstZRem", Z | Rem, 64'd0);
      chk("midRstFlags", {60'd0, Eq, Gt, Lt, DivZero}, 64'd0);
      #3;
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      send(64'd12, 64'd4, 64'd0);
      recv(0);
      chk("afterRstZ", Z, 64'd11);

      chk("scoreboardDrained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
